msg_bus_hub: RTL and testbench
==============================

Name: msg_bus_hub

Overview:
- Central end of the cache-coherence message bus. Each cache's message controller raises msg_req/msg and collects rsp_valid/msg_rsp; this block is what answers them.
- Round-robin arbitrates the per-cache message requests and broadcasts one granted message per cycle to all caches on a shared registered bus.
- Tracks every outstanding coherence request until all peer acks have crossed the bus. Flags protocol violations.

Parameters:
- cache_num, 4, number of attached caches; must be at least 2.
- id_w, $clog2(cache_num), width of the ta/ra id fields.
- msg_w, 4 + 2*id_w, message width, packed as {code[3:0], ta, ra}.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- msg_req  input  cache_num  bit i: cache i requests the bus
- msg_in  input  cache_num*msg_w  slice i: message of cache i
- msg_gnt  output  cache_num  one-hot grant; handshake for port i is msg_req[i] && msg_gnt[i]
- rsp_valid  output  1  broadcast message valid
- msg_rsp  output  msg_w  broadcast message
- wr_done  output  cache_num  1-cycle pulse: cache i's 4'b100 request has been fully acked
- rd_done  output  cache_num  1-cycle pulse: cache i's 4'b101 request has been fully acked
- proto_err  output  1  1-cycle pulse on any protocol violation

Behaviour:
- Reset (rst=1 at a posedge):
  - rsp_valid=0, msg_rsp=0, wr_done=0, rd_done=0, proto_err=0.
  - Round-robin pointer=0; all tracker state cleared.
  - A reset mid-operation discards any in-flight message; rsp_valid is 0 in the following cycle.
- Arbitration:
  - msg_gnt is combinational from msg_req and the pointer: the first requester at or after the pointer, searching upward with wrap.
  - The bus never stalls: any nonzero msg_req yields exactly one grant in the same cycle.
  - After a grant to port g, pointer <= (g+1) mod cache_num. With no request, the pointer holds.
  - A requester holds msg_in stable until granted. Back-to-back grants to different ports are allowed.
- Broadcast:
  - Handshake in cycle T gives rsp_valid=1 and msg_rsp = msg_in slice g in cycle T+1. Latency 1, throughput 1 message/cycle.
  - With no handshake, rsp_valid=0 and msg_rsp holds its last value.
  - The message is forwarded unmodified in all cases. Caches filter by code and ra.
  - Code 4'b100 (write request) and 4'b101 (read request) are broadcasts; their ra field is don't-care.
- Tracker: one {busy, peer bitmap} per (cache, type), 2*cache_num entries. It updates only on cycles where rsp_valid=1, using the msg_rsp fields.
  - Code 4'b100 from ta=s: wr_busy[s]=1, wr_map[s]=one-hot(s).
  - Code 4'b101 from ta=s: rd_busy[s]=1, rd_map[s]=one-hot(s).
  - Codes 4'b010/4'b011 with ra=r, ta=t, wr_busy[r]=1: set wr_map[r][t].
  - Code 4'b000 with ra=r, ta=t, rd_busy[r]=1: set rd_map[r][t].
  - When a map becomes all-ones: the matching done[r] pulses in the next cycle and busy clears.
  - A new request from r arriving in the same cycle a done pulse for r is output starts a fresh transaction (new request wins).
  - Other codes: forwarded, no tracker effect.
- proto_err pulses one cycle after the offending broadcast:
  - An ack to a non-busy tracker, or an ack whose ta bit is already set; the ack is ignored.
  - A request while the same-type tracker is busy; the tracker restarts.
  - A granted message whose ta differs from its port index; it is still forwarded and tracked by ta.
  - An ack with ta=ra.
  - ra or ta >= cache_num; the message is ignored by the tracker.
- Width rule: ta/ra are compared as unsigned id_w-bit values.

Test Plan:
- Reset, then msg_req=4'b0001 with msg_in[0]={4'b100,0,3}: msg_gnt=0001 in the same cycle; next cycle rsp_valid=1, msg_rsp={4'b100,0,3}.
- msg_req=4'b1111 held for 4 cycles from reset: grants 0001, 0010, 0100, 1000 in order; 4 consecutive rsp_valid cycles.
- Cache 0 sends 4'b101, then caches 1/2/3 send {4'b000,t,0}: rd_done[0] pulses exactly one cycle after the third ack's broadcast; rd_busy[0] clears.
- Cache 2 sends 4'b100, then acks 4'b010 from 0, 4'b011 from 1, and a duplicate from 1: duplicate gives proto_err=1, no wr_done; ack from 3 then gives wr_done[2].
- Cache 1 sends concurrent 4'b100 and 4'b101; acks interleaved (000 from 0, 010 from 0, ...): wr_done[1] and rd_done[1] each fire exactly once, with no cross-talk between types.
- Assert rst while rd_busy[0]=1 and a message is in flight: rsp_valid=0 next cycle; a later ack {4'b000,1,0} raises proto_err.

Source files
------------

// File: rtl/msg_bus_hub.sv
// msg_bus_hub: round-robin arbiter and registered broadcast bus for the coherence
// message network, with per-cache request/ack tracking and protocol checking.
module msg_bus_hub #(
  parameter int cache_num = 4,
  parameter int id_w      = $clog2(cache_num),
  parameter int msg_w     = 4 + 2*id_w
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [cache_num-1:0]       msg_req,
  input  logic [cache_num*msg_w-1:0] msg_in,
  output logic [cache_num-1:0]       msg_gnt,
  output logic                       rsp_valid,
  output logic [msg_w-1:0]           msg_rsp,
  output logic [cache_num-1:0]       wr_done,
  output logic [cache_num-1:0]       rd_done,
  output logic                       proto_err
);

  localparam int cw = id_w + 1;
  localparam logic [3:0] WR_REQ  = 4'b0100;
  localparam logic [3:0] RD_REQ  = 4'b0101;
  localparam logic [3:0] WR_ACK0 = 4'b0010;
  localparam logic [3:0] WR_ACK1 = 4'b0011;
  localparam logic [3:0] RD_ACK  = 4'b0000;

  logic [id_w-1:0]      ptr;
  logic [id_w-1:0]      gnt_idx;
  logic [id_w-1:0]      rsp_port;
  logic [cw-1:0]        cand;
  logic                 found;
  logic [msg_w-1:0]     gnt_msg;

  logic [3:0]           code;
  logic [id_w-1:0]      ta;
  logic [id_w-1:0]      ra;
  logic [cache_num-1:0] ta_oh;
  logic                 ta_ok;
  logic                 ra_ok;
  logic                 is_wr_req;
  logic                 is_rd_req;
  logic                 is_wr_ack;
  logic                 is_rd_ack;
  logic                 ack_ids_ok;
  logic                 wr_ack_ok;
  logic                 rd_ack_ok;
  logic                 err_now;

  logic [cache_num-1:0] wr_busy;
  logic [cache_num-1:0] rd_busy;
  logic [cache_num-1:0] wr_map [cache_num];
  logic [cache_num-1:0] rd_map [cache_num];

  // First requester at or after the pointer, searching upward with wrap.
  always_comb begin
    msg_gnt = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < cache_num; i++) begin
      cand = {1'b0, ptr} + cw'(i);
      if (cand >= cw'(cache_num)) cand = cand - cw'(cache_num);
      if (!found && msg_req[cand[id_w-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[id_w-1:0];
      end
    end
    if (found) msg_gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    gnt_msg = '0;
    for (int i = 0; i < cache_num; i++) begin
      if (msg_gnt[i]) gnt_msg = msg_in[i*msg_w +: msg_w];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      rsp_valid <= 1'b0;
      msg_rsp   <= '0;
      rsp_port  <= '0;
    end else begin
      rsp_valid <= found;
      if (found) begin
        msg_rsp  <= gnt_msg;
        rsp_port <= gnt_idx;
        ptr      <= (gnt_idx == id_w'(cache_num - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  assign code  = msg_rsp[msg_w-1 -: 4];
  assign ta    = msg_rsp[2*id_w-1 -: id_w];
  assign ra    = msg_rsp[id_w-1:0];
  assign ta_oh = cache_num'(1) << ta;

  // Ids can only be out of range when cache_num is not a power of two.
  if (cache_num == (1 << id_w)) begin : g_full_ids
    assign ta_ok = 1'b1;
    assign ra_ok = 1'b1;
  end else begin : g_part_ids
    assign ta_ok = ta < id_w'(cache_num);
    assign ra_ok = ra < id_w'(cache_num);
  end

  assign is_wr_req  = (code == WR_REQ);
  assign is_rd_req  = (code == RD_REQ);
  assign is_wr_ack  = (code == WR_ACK0) || (code == WR_ACK1);
  assign is_rd_ack  = (code == RD_ACK);
  assign ack_ids_ok = ta_ok && ra_ok && (ta != ra);
  assign wr_ack_ok  = is_wr_ack && ack_ids_ok && wr_busy[ra] && !wr_map[ra][ta];
  assign rd_ack_ok  = is_rd_ack && ack_ids_ok && rd_busy[ra] && !rd_map[ra][ta];

  assign err_now = (ta != rsp_port)
                || ((is_wr_req || is_rd_req) &&
                    (!ta_ok || (is_wr_req && wr_busy[ta]) || (is_rd_req && rd_busy[ta])))
                || (is_wr_ack && !wr_ack_ok)
                || (is_rd_ack && !rd_ack_ok);

  // Tracker reacts to the registered broadcast, so done/err land one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_busy   <= '0;
      rd_busy   <= '0;
      wr_done   <= '0;
      rd_done   <= '0;
      proto_err <= 1'b0;
      for (int i = 0; i < cache_num; i++) begin
        wr_map[i] <= '0;
        rd_map[i] <= '0;
      end
    end else begin
      wr_done   <= '0;
      rd_done   <= '0;
      proto_err <= rsp_valid && err_now;
      if (rsp_valid) begin
        if (is_wr_req && ta_ok) begin
          wr_busy[ta] <= 1'b1;
          wr_map[ta]  <= ta_oh;
        end
        if (is_rd_req && ta_ok) begin
          rd_busy[ta] <= 1'b1;
          rd_map[ta]  <= ta_oh;
        end
        if (wr_ack_ok) begin
          wr_map[ra] <= wr_map[ra] | ta_oh;
          if ((wr_map[ra] | ta_oh) == '1) begin
            wr_busy[ra] <= 1'b0;
            wr_done[ra] <= 1'b1;
          end
        end
        if (rd_ack_ok) begin
          rd_map[ra] <= rd_map[ra] | ta_oh;
          if ((rd_map[ra] | ta_oh) == '1) begin
            rd_busy[ra] <= 1'b0;
            rd_done[ra] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_msg_bus_hub.sv
// tb_msg_bus_hub: directed, self-checking bench for msg_bus_hub with four caches.
module tb_msg_bus_hub;

  localparam int N  = 4;
  localparam int MW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    msg_req;
  logic [N*MW-1:0] msg_in;
  logic [N-1:0]    msg_gnt;
  logic            rsp_valid;
  logic [MW-1:0]   msg_rsp;
  logic [N-1:0]    wr_done;
  logic [N-1:0]    rd_done;
  logic            proto_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  msg_bus_hub #(.cache_num(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .msg_req   (msg_req),
    .msg_in    (msg_in),
    .msg_gnt   (msg_gnt),
    .rsp_valid (rsp_valid),
    .msg_rsp   (msg_rsp),
    .wr_done   (wr_done),
    .rd_done   (rd_done),
    .proto_err (proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    msg_req = '0;
    msg_in  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One granted message from port p; returns in the cycle it is on the bus.
  task automatic send(input int p, input logic [3:0] c, input logic [1:0] t, input logic [1:0] r);
    msg_req              = '0;
    msg_req[p]           = 1'b1;
    msg_in[p*MW +: MW]   = {c, t, r};
    tick();
    msg_req = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({rsp_valid, msg_rsp} !== 9'd0) begin
      n_err++; $display("[TB] FAIL reset_bus: got %b/%h expected 0/00", rsp_valid, msg_rsp);
    end
    n_vec++;
    if ({wr_done, rd_done, proto_err} !== 9'd0) begin
      n_err++; $display("[TB] FAIL reset_flags: got %b %b %b expected 0", wr_done, rd_done, proto_err);
    end
    n_vec++;
    if (msg_gnt !== 4'b0000) begin
      n_err++; $display("[TB] FAIL reset_idle_gnt: got %b expected 0000", msg_gnt);
    end
  endtask

  task automatic test_single_grant();
    do_reset();
    msg_req   = 4'b0001;
    msg_in[7:0] = {4'b0100, 2'd0, 2'd3};
    #1;
    n_vec++;
    if (msg_gnt !== 4'b0001) begin
      n_err++; $display("[TB] FAIL single_gnt: got %b expected 0001", msg_gnt);
    end
    tick();
    msg_req = '0;
    n_vec++;
    if ({rsp_valid, msg_rsp} !== {1'b1, 4'b0100, 2'd0, 2'd3}) begin
      n_err++; $display("[TB] FAIL single_bcast: got %b/%h expected 1/43", rsp_valid, msg_rsp);
    end
    tick();
    n_vec++;
    if ({rsp_valid, msg_rsp, proto_err} !== {1'b0, 8'h43, 1'b0}) begin
      n_err++; $display("[TB] FAIL single_hold: got %b/%h err %b expected 0/43 err 0", rsp_valid, msg_rsp, proto_err);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] req_t [6];
    logic [3:0] gnt_t [6];
    logic       vld_t [6];
    logic [1:0] ta_t  [6];
    req_t = '{4'b1010, 4'b1010, 4'b0110, 4'b0100, 4'b0000, 4'b1001};
    gnt_t = '{4'b0010, 4'b1000, 4'b0010, 4'b0100, 4'b0000, 4'b1000};
    vld_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    ta_t  = '{2'd1, 2'd3, 2'd1, 2'd2, 2'd2, 2'd3};
    do_reset();
    for (int p = 0; p < N; p++) msg_in[p*MW +: MW] = {4'b0111, 2'(p), 2'd0};
    msg_req = 4'b1111;
    for (int k = 0; k < N; k++) begin
      #1;
      n_vec++;
      if (msg_gnt !== 4'(1 << k)) begin
        n_err++; $display("[TB] FAIL rr_all_gnt%0d: got %b expected %b", k, msg_gnt, 4'(1 << k));
      end
      tick();
      n_vec++;
      if ({rsp_valid, msg_rsp} !== {1'b1, 4'b0111, 2'(k), 2'd0}) begin
        n_err++; $display("[TB] FAIL rr_all_bcast%0d: got %b/%h", k, rsp_valid, msg_rsp);
      end
    end
    for (int k = 0; k < 6; k++) begin
      msg_req = req_t[k];
      #1;
      n_vec++;
      if (msg_gnt !== gnt_t[k]) begin
        n_err++; $display("[TB] FAIL rr_pat_gnt%0d: got %b expected %b", k, msg_gnt, gnt_t[k]);
      end
      tick();
      n_vec++;
      if ({rsp_valid, msg_rsp} !== {vld_t[k], 4'b0111, ta_t[k], 2'd0}) begin
        n_err++; $display("[TB] FAIL rr_pat_bcast%0d: got %b/%h expected %b/%h", k, rsp_valid, msg_rsp,
                          vld_t[k], {4'b0111, ta_t[k], 2'd0});
      end
    end
    msg_req = '0;
    tick();
    n_vec++;
    if (proto_err !== 1'b0) begin
      n_err++; $display("[TB] FAIL rr_no_err: got %b expected 0", proto_err);
    end
  endtask

  task automatic test_read_done();
    do_reset();
    send(0, 4'b0101, 2'd0, 2'd0);
    tick();
    for (int t = 1; t < N; t++) begin
      send(t, 4'b0000, 2'(t), 2'd0);
      tick();
      n_vec++;
      if ({rd_done, wr_done, proto_err} !== {(t == 3) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0}) begin
        n_err++; $display("[TB] FAIL rd_ack%0d: got rd %b wr %b err %b", t, rd_done, wr_done, proto_err);
      end
    end
    tick();
    n_vec++;
    if (rd_done !== 4'b0000) begin
      n_err++; $display("[TB] FAIL rd_pulse_width: got %b expected 0000", rd_done);
    end
    send(1, 4'b0000, 2'd1, 2'd0);
    tick();
    n_vec++;
    if (proto_err !== 1'b1) begin
      n_err++; $display("[TB] FAIL rd_busy_cleared: got err %b expected 1", proto_err);
    end
  endtask

  task automatic test_write_dup();
    int         sp [5];
    logic [3:0] sc [5];
    logic       se [5];
    logic [3:0] sw [5];
    sp = '{0, 1, 1, 3, 0};
    sc = '{4'b0010, 4'b0011, 4'b0011, 4'b0010, 4'b0000};
    se = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    sw = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
    do_reset();
    send(2, 4'b0100, 2'd2, 2'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      send(sp[k], sc[k], 2'(sp[k]), 2'd2);
      tick();
      n_vec++;
      if ({proto_err, wr_done} !== {se[k], sw[k]}) begin
        n_err++; $display("[TB] FAIL wr_dup_step%0d: got err %b wr %b expected err %b wr %b",
                          k, proto_err, wr_done, se[k], sw[k]);
      end
    end
  endtask

  task automatic test_concurrent();
    int         cp [6];
    logic [3:0] cc [6];
    logic [3:0] ew [6];
    logic [3:0] er [6];
    cp = '{0, 0, 2, 2, 3, 3};
    cc = '{4'b0000, 4'b0010, 4'b0000, 4'b0011, 4'b0000, 4'b0010};
    ew = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
    er = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    do_reset();
    send(1, 4'b0100, 2'd1, 2'd0);
    tick();
    send(1, 4'b0101, 2'd1, 2'd0);
    tick();
    n_vec++;
    if (proto_err !== 1'b0) begin
      n_err++; $display("[TB] FAIL cc_reqs_err: got %b expected 0", proto_err);
    end
    for (int k = 0; k < 6; k++) begin
      send(cp[k], cc[k], 2'(cp[k]), 2'd1);
      tick();
      n_vec++;
      if ({wr_done, rd_done, proto_err} !== {ew[k], er[k], 1'b0}) begin
        n_err++; $display("[TB] FAIL cc_ack%0d: got wr %b rd %b err %b expected wr %b rd %b err 0",
                          k, wr_done, rd_done, proto_err, ew[k], er[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int         bp [5];
    logic [7:0] bm [5];
    bp = '{0, 1, 2, 3, 0};
    bm = '{{4'b0101, 2'd0, 2'd0}, {4'b0000, 2'd1, 2'd0}, {4'b0000, 2'd2, 2'd0},
           {4'b0000, 2'd3, 2'd0}, {4'b0101, 2'd0, 2'd0}};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      msg_req = 4'(1 << bp[k]);
      msg_in[bp[k]*MW +: MW] = bm[k];
      #1;
      n_vec++;
      if (msg_gnt !== 4'(1 << bp[k])) begin
        n_err++; $display("[TB] FAIL b2b_gnt%0d: got %b expected %b", k, msg_gnt, 4'(1 << bp[k]));
      end
      tick();
      n_vec++;
      if ({rsp_valid, msg_rsp, rd_done} !== {1'b1, bm[k], (k == 4) ? 4'b0001 : 4'b0000}) begin
        n_err++; $display("[TB] FAIL b2b_bcast%0d: got %b/%h rd %b", k, rsp_valid, msg_rsp, rd_done);
      end
    end
    msg_req = '0;
    tick();
    n_vec++;
    if ({rsp_valid, proto_err, rd_done} !== 6'd0) begin
      n_err++; $display("[TB] FAIL b2b_restart: got vld %b err %b rd %b expected 0", rsp_valid, proto_err, rd_done);
    end
    send(1, 4'b0000, 2'd1, 2'd0);
    tick();
    n_vec++;
    if (proto_err !== 1'b0) begin
      n_err++; $display("[TB] FAIL b2b_fresh_busy: got err %b expected 0", proto_err);
    end
  endtask

  task automatic test_proto_errors();
    int         pp [10];
    logic [3:0] pc [10];
    logic [1:0] pt [10];
    logic [1:0] pr [10];
    logic       pe [10];
    logic [3:0] pw [10];
    pp = '{1, 0, 0, 1, 0, 1, 2, 3, 3, 2};
    pc = '{4'b0111, 4'b0100, 4'b0010, 4'b0010, 4'b0100, 4'b0011, 4'b0010, 4'b0010, 4'b0101, 4'b0000};
    pt = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
    pr = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0};
    pe = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    pw = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      send(pp[k], pc[k], pt[k], pr[k]);
      tick();
      n_vec++;
      if ({proto_err, wr_done} !== {pe[k], pw[k]}) begin
        n_err++; $display("[TB] FAIL perr_step%0d: got err %b wr %b expected err %b wr %b",
                          k, proto_err, wr_done, pe[k], pw[k]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    send(0, 4'b0101, 2'd0, 2'd0);
    tick();
    msg_req     = 4'b0010;
    msg_in[15:8] = {4'b0000, 2'd1, 2'd0};
    tick();
    rst     = 1'b1;
    msg_req = '0;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({rsp_valid, rd_done, proto_err} !== 6'd0) begin
      n_err++; $display("[TB] FAIL mid_reset_bus: got vld %b rd %b err %b expected 0", rsp_valid, rd_done, proto_err);
    end
    send(1, 4'b0000, 2'd1, 2'd0);
    tick();
    n_vec++;
    if ({proto_err, rd_done} !== 5'b1_0000) begin
      n_err++; $display("[TB] FAIL mid_reset_tracker: got err %b rd %b expected err 1 rd 0000", proto_err, rd_done);
    end
  endtask

  initial begin
    rst     = 1'b1;
    msg_req = '0;
    msg_in  = '0;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_read_done();
    test_write_dup();
    test_concurrent();
    test_back_to_back();
    test_proto_errors();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
